// File: rtl/avr_xmem_master.sv
// Bus initiator for the AVR-style multiplexed external-memory bus (ALE, WD/RD, muxed AD, high A).
// Optional `XMEM_READY_EN: STROBE extends past its minimum length while ready is low.
module avr_xmem_master #(
  parameter int WAIT_STATES = 1,
  parameter int HOLD_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        done,
  output logic        busy,
  output logic        ale,
  output logic        wd,
  output logic        rd,
  output logic [7:0]  ad_o,
  output logic        ad_oe,
  input  logic [7:0]  ad_i,
  output logic [7:0]  a,
  input  logic        ready
);
  typedef enum logic [2:0] {IDLE, ADDR, LATCH, STROBE, HOLD} state_t;

  localparam logic [3:0] WS = 4'(WAIT_STATES);
  localparam logic [3:0] HC = 4'(HOLD_CYCLES - 1);

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic        we_q, we_n;
  logic [15:0] addr_q, addr_n;
  logic [7:0]  wdata_q, wdata_n;
  logic        ale_n, wd_n, rd_n, ad_oe_n, done_n, busy_n;
  logic [7:0]  ad_o_n, a_n, rdata_n;
  logic        strobe_end;

`ifdef XMEM_READY_EN
  assign strobe_end = (cnt == 4'd0) && ready;
`else
  logic unused_ready;
  assign unused_ready = ready;
  assign strobe_end   = (cnt == 4'd0);
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    we_n    = we_q;
    addr_n  = addr_q;
    wdata_n = wdata_q;
    rdata_n = rdata;
    case (state)
      IDLE: if (req) begin
        we_n    = we;
        addr_n  = addr;
        wdata_n = wdata;
        state_n = ADDR;
      end
      ADDR:  state_n = LATCH;
      LATCH: begin
        state_n = STROBE;
        cnt_n   = WS;
      end
      STROBE: if (strobe_end) begin
        state_n = HOLD;
        cnt_n   = HC;
        if (!we_q) rdata_n = ad_i;
      end else if (cnt != 4'd0) begin
        cnt_n = cnt - 4'd1;
      end
      HOLD: if (cnt == 4'd0) state_n = IDLE;
            else             cnt_n   = cnt - 4'd1;
      default: state_n = IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    ale_n   = 1'b0;
    wd_n    = 1'b1;
    rd_n    = 1'b1;
    ad_oe_n = 1'b0;
    ad_o_n  = 8'h00;
    a_n     = a;
    done_n  = (state == HOLD) && (state_n == IDLE);
    busy_n  = (state_n != IDLE);
    case (state_n)
      ADDR, LATCH: begin
        ale_n   = (state_n == ADDR);
        ad_oe_n = 1'b1;
        ad_o_n  = addr_n[7:0];
        a_n     = addr_n[15:8];
      end
      STROBE: if (we_n) begin
        wd_n    = 1'b0;
        ad_oe_n = 1'b1;
        ad_o_n  = wdata_n;
      end else begin
        rd_n    = 1'b0;
      end
      HOLD: if (we_n) begin
        ad_oe_n = 1'b1;
        ad_o_n  = wdata_n;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 16'h0000;
      wdata_q <= 8'h00;
      ale     <= 1'b0;
      wd      <= 1'b1;
      rd      <= 1'b1;
      ad_oe   <= 1'b0;
      ad_o    <= 8'h00;
      a       <= 8'h00;
      rdata   <= 8'h00;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      we_q    <= we_n;
      addr_q  <= addr_n;
      wdata_q <= wdata_n;
      ale     <= ale_n;
      wd      <= wd_n;
      rd      <= rd_n;
      ad_oe   <= ad_oe_n;
      ad_o    <= ad_o_n;
      a       <= a_n;
      rdata   <= rdata_n;
      done    <= done_n;
      busy    <= busy_n;
    end
  end
endmodule

// File: tb/tb_avr_xmem_master.sv
// Bench for avr_xmem_master: default instance plus a WAIT_STATES=3/HOLD_CYCLES=2 instance,
// a bus slave memory, and a cycle-offset reference of the expected bus waveform.
module tb_avr_xmem_master;
  logic clk = 1'b0;
  logic reset, req, we, ready, sel;
  logic [15:0] addr;
  logic [7:0] wdata, ad_i;
  always #5 clk = ~clk;

  logic [7:0] rdata1, ad_o1, a1, rdata2, ad_o2, a2;
  logic done1, busy1, ale1, wd1, rd1, oe1, done2, busy2, ale2, wd2, rd2, oe2;
  logic req1, req2;
  assign req1 = req & ~sel;
  assign req2 = req & sel;

  avr_xmem_master u_dut1 (.clk(clk), .reset(reset), .req(req1), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata1), .done(done1), .busy(busy1), .ale(ale1), .wd(wd1), .rd(rd1), .ad_o(ad_o1),
    .ad_oe(oe1), .ad_i(ad_i), .a(a1), .ready(ready));
  avr_xmem_master #(.WAIT_STATES(3), .HOLD_CYCLES(2)) u_dut2 (.clk(clk), .reset(reset), .req(req2),
    .we(we), .addr(addr), .wdata(wdata), .rdata(rdata2), .done(done2), .busy(busy2), .ale(ale2),
    .wd(wd2), .rd(rd2), .ad_o(ad_o2), .ad_oe(oe2), .ad_i(ad_i), .a(a2), .ready(ready));

  logic [7:0] c_rdata, c_ad_o, c_a;
  logic c_done, c_busy, c_ale, c_wd, c_rd, c_oe;
  always_comb begin
    if (sel) begin
      c_rdata = rdata2; c_ad_o = ad_o2; c_a = a2; c_done = done2; c_busy = busy2;
      c_ale = ale2; c_wd = wd2; c_rd = rd2; c_oe = oe2;
    end else begin
      c_rdata = rdata1; c_ad_o = ad_o1; c_a = a1; c_done = done1; c_busy = busy1;
      c_ale = ale1; c_wd = wd1; c_rd = rd1; c_oe = oe1;
    end
  end

  // Power-on contents of untouched slave locations
  function automatic logic [7:0] dflt(input logic [15:0] ad);
    return ad[7:0] ^ ad[15:8] ^ 8'hDE;
  endfunction

  // Slave: latches low address on ALE, writes on WD low, drives AD only while RD low
  logic [7:0] smem [0:65535];
  logic       wrt  [0:65535];
  logic [7:0] lat = 8'h00;
  logic [7:0] noise = 8'h00;
  always @(posedge clk) begin
    noise <= 8'($urandom);
    if (c_ale) lat <= c_ad_o;
    if (!c_wd) begin
      smem[{c_a, lat}] <= c_ad_o;
      wrt[{c_a, lat}]  <= 1'b1;
    end
  end
  assign ad_i = !c_rd ? ((wrt[{c_a, lat}] === 1'b1) ? smem[{c_a, lat}] : dflt({c_a, lat})) : noise;

  logic [7:0] refm [logic [15:0]];
  int n_chk = 0, n_fail = 0, cur_k = 0;

  task automatic chk(input string tag, input logic [7:0] o, input logic [7:0] e);
    n_chk++;
    if (o !== e) begin
      n_fail++;
      $error("FAIL %s k=%0d obs=%0h exp=%0h", tag, cur_k, o, e);
    end
  endtask

  function automatic logic [7:0] ref_rd(input logic [15:0] ad);
    return refm.exists(ad) ? refm[ad] : dflt(ad);
  endfunction

  // Expected bus state k cycles after the accept edge: strobe lasts s cycles, hold h cycles.
  task automatic chk_cycle(input int k, input bit w, input logic [15:0] ad, input logic [7:0] d,
                           input int s, input int h, input logic [7:0] rexp);
    int dk;
    bit in_str, oe_e;
    dk = 3 + s + h;
    cur_k = k;
    in_str = (k >= 3) && (k < 3 + s);
    oe_e = (k <= 2) || (w && k >= 3 && k < 3 + s + h);
    chk("ale", c_ale, 1'(k == 1));
    chk("wd", c_wd, 1'(!(w && in_str)));
    chk("rd", c_rd, 1'(!(!w && in_str)));
    chk("ad_oe", c_oe, 1'(oe_e));
    if (oe_e) chk("ad_o", c_ad_o, ((k <= 2) ? ad[7:0] : d));
    if (k == dk) chk("ad_o_idle", c_ad_o, 8'h00);
    chk("a", c_a, ad[15:8]);
    chk("busy", c_busy, 1'(k < dk));
    chk("done", c_done, 1'(k == dk));
    if (k == dk && !w) chk("rdata", c_rdata, rexp);
  endtask

  // One transaction on the selected instance; ready held low for rlow cycles past the minimum strobe.
  task automatic txn(input bit w, input logic [15:0] ad, input logic [7:0] d, input int rlow);
    int smin, s, h;
    logic [7:0] rexp;
    smin = sel ? 4 : 2;
    h    = sel ? 2 : 1;
    s    = smin;
`ifdef XMEM_READY_EN
    s = smin + rlow;
`endif
    rexp = ref_rd(ad);
    if (w) refm[ad] = d;
    req = 1'b1; we = w; addr = ad; wdata = d;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    for (int k = 1; k <= 3 + s + h; k++) begin
      ready = !(k >= 2 + smin && k < 2 + smin + rlow);
      chk_cycle(k, w, ad, d, s, h, rexp);
      @(negedge clk);
    end
    ready = 1'b1;
    cur_k = 4 + s + h;
    chk("done_single", c_done, 1'b0);
    chk("busy_after", c_busy, 1'b0);
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; we = 1'b0; ready = 1'b1; sel = 1'b0;
    addr = 16'h0000; wdata = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_ale", ale1, 1'b0);
    chk("rst_wd", wd1, 1'b1);
    chk("rst_rd", rd1, 1'b1);
    chk("rst_oe", oe1, 1'b0);
    chk("rst_ad_o", ad_o1, 8'h00);
    chk("rst_a", a1, 8'h00);
    chk("rst_rdata", rdata1, 8'h00);
    chk("rst_done", done1, 1'b0);
    chk("rst_busy", busy1, 1'b0);
    chk("rst_busy2", busy2, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    req = 1'b1; we = 1'b1; addr = 16'h0777; wdata = 8'h11;
    @(posedge clk);
    @(negedge clk); req = 1'b0;
    repeat (2) @(negedge clk);
    cur_k = 3;
    chk("mid_wd_low", wd1, 1'b0);
    refm[16'h0777] = 8'h11;
    reset = 1'b1;
    @(negedge clk);
    cur_k = 4;
    chk("mid_wd", wd1, 1'b1);
    chk("mid_oe", oe1, 1'b0);
    chk("mid_ale", ale1, 1'b0);
    chk("mid_busy", busy1, 1'b0);
    chk("mid_done", done1, 1'b0);
    chk("mid_a", a1, 8'h00);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("mid_no_done", done1, 1'b0);
      chk("mid_idle", busy1, 1'b0);
    end

    txn(1'b1, 16'h12A5, 8'h3C, 0);
    cur_k = 0;
    chk("slave_12A5", smem[16'h12A5], 8'h3C);
    txn(1'b0, 16'h0480, 8'h00, 0);

    req = 1'b1; we = 1'b1; addr = 16'h0001; wdata = 8'hA1;
    @(posedge clk);
    @(negedge clk);
    addr = 16'h0002; wdata = 8'hB2;
    for (int k = 1; k <= 12; k++) begin
      if (k <= 6) chk_cycle(k, 1'b1, 16'h0001, 8'hA1, 2, 1, 8'h00);
      else        chk_cycle(k - 6, 1'b1, 16'h0002, 8'hB2, 2, 1, 8'h00);
      if (k == 7) req = 1'b0;
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      cur_k = 13 + i;
      chk("b2b_no_third", c_busy, 1'b0);
      chk("b2b_no_ale", c_ale, 1'b0);
      @(negedge clk);
    end
    refm[16'h0001] = 8'hA1;
    refm[16'h0002] = 8'hB2;

    sel = 1'b1;
    txn(1'b0, 16'h0480, 8'h00, 0);
    txn(1'b1, 16'h3344, 8'h9D, 0);
    sel = 1'b0;

    txn(1'b0, 16'h0480, 8'h00, 3);

    for (int i = 0; i < 24; i++) begin
      sel = 1'($urandom_range(0, 1));
      txn(1'($urandom_range(0, 1)), 16'h2000 + 16'($urandom_range(0, 15)), 8'($urandom),
          int'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    sel = 1'b0;

    cur_k = 0;
    foreach (refm[k]) chk("mem", smem[k], refm[k]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
